// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - fetch/decode/wait/execute control FSM for the EnDMe accumulator processor
// Optional performance counters: define MULTICYCLE_CTRL_PERF_EN.

package definitions;

  typedef enum logic [3:0] {
    ADD   = 4'h0,
    SUB   = 4'h1,
    AND   = 4'h2,
    XOR   = 4'h3,
    SFL   = 4'h4,
    SFR   = 4'h5,
    CMP   = 4'h6,
    GTR   = 4'h7,
    STORE = 4'h8,
    LB    = 4'h9,
    SB    = 4'hA,
    PUT   = 4'hB,
    BTR   = 4'hC,
    JMP   = 4'hD,
    NOP   = 4'hE,
    HALT  = 4'hF
  } Instr_O;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SFL = 3'd4,
    ALU_SFR = 3'd5,
    ALU_EQU = 3'd6,
    ALU_GTR = 3'd7
  } Alu_Op;

endpackage

module multicycle_controller
  import definitions::*;
#(
  parameter int          MEM_LAT = 1,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter logic [3:0]  NOP_OP  = 4'hE,
  parameter int          PERF_W  = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              TYP,
  input  logic [3:0]        OP,
  output logic              launch,
  output logic              done,
  output logic              busy,
  output logic              ir_load,
  output logic              pc_en,
  output logic              br_ctrl,
  output logic              jmp_ctrl,
  output logic              regwrite_ctrl,
  output logic [2:0]        aluop_ctrl,
  output logic              memwrite_ctrl,
  output logic [1:0]        accdata_ctrl,
  output logic              accwrite_ctrl
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_count,
  output logic [PERF_W-1:0] instr_count
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("multicycle_controller: MEM_LAT must be within 1..15");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("multicycle_controller: PERF_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       dtyp_q, dtyp_d;
  logic [3:0] dop_q, dop_d;
  logic [3:0] wcnt_q, wcnt_d;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dtyp_q  <= 1'b0;
      dop_q   <= 4'h0;
      wcnt_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      dtyp_q  <= dtyp_d;
      dop_q   <= dop_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // launch is the only output that depends on an input, and only on start.
  always_comb begin
    state_d = state_q;
    dtyp_d  = dtyp_q;
    dop_d   = dop_q;
    wcnt_d  = wcnt_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          launch  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        dtyp_d = TYP;
        dop_d  = OP;
        if (!TYP && OP == HALT_OP) begin
          state_d = S_HALT;
        end else if (!TYP && OP == LB) begin
          state_d = S_MEM_WAIT;
          wcnt_d  = 4'(MEM_LAT - 1);
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM_WAIT: begin
        if (wcnt_q == 4'h0) state_d = S_EXEC;
        else                wcnt_d  = wcnt_q - 4'h1;
      end
      S_EXEC:  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  logic       dec_br, dec_jmp, dec_regw, dec_memw, dec_accw;
  logic [2:0] dec_alu;
  logic [1:0] dec_accdata;

  always_comb begin
    dec_br      = 1'b0;
    dec_jmp     = 1'b0;
    dec_regw    = 1'b0;
    dec_memw    = 1'b0;
    dec_accw    = 1'b0;
    dec_alu     = ALU_ADD;
    dec_accdata = 2'b00;
    if (dtyp_q) begin
      dec_accw = 1'b1;
    end else if (dop_q == NOP_OP) begin
      dec_accw = 1'b0;
    end else begin
      case (Instr_O'(dop_q))
        STORE: dec_regw = 1'b1;
        LB:    begin dec_accdata = 2'b10; dec_accw = 1'b1; end
        SB:    dec_memw = 1'b1;
        PUT:   begin dec_accdata = 2'b01; dec_accw = 1'b1; end
        BTR:   dec_br  = 1'b1;
        JMP:   dec_jmp = 1'b1;
        ADD:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_ADD; end
        SUB:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_SUB; end
        AND:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_AND; end
        XOR:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_XOR; end
        SFL:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_SFL; end
        SFR:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_SFR; end
        CMP:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_EQU; end
        GTR:   begin dec_accdata = 2'b11; dec_accw = 1'b1; dec_alu = ALU_GTR; end
        default: dec_accw = 1'b0;
      endcase
    end
  end

  // Mux selects are held across MEM_WAIT so the datapath settles before the EXEC write.
  always_comb begin
    done          = (state_q == S_HALT);
    busy          = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_MEM_WAIT) || (state_q == S_EXEC);
    ir_load       = (state_q == S_FETCH);
    pc_en         = (state_q == S_EXEC);
    br_ctrl       = 1'b0;
    jmp_ctrl      = 1'b0;
    regwrite_ctrl = 1'b0;
    memwrite_ctrl = 1'b0;
    accwrite_ctrl = 1'b0;
    aluop_ctrl    = ALU_ADD;
    accdata_ctrl  = 2'b00;
    if (state_q == S_MEM_WAIT || state_q == S_EXEC) begin
      aluop_ctrl   = dec_alu;
      accdata_ctrl = dec_accdata;
    end
    if (state_q == S_EXEC) begin
      br_ctrl       = dec_br;
      jmp_ctrl      = dec_jmp;
      regwrite_ctrl = dec_regw;
      memwrite_ctrl = dec_memw;
      accwrite_ctrl = dec_accw;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [PERF_W-1:0] cyc_q, ins_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (launch) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (busy && !(&cyc_q))                  cyc_q <= cyc_q + 1'b1;
      if ((state_q == S_EXEC) && !(&ins_q))   ins_q <= ins_q + 1'b1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`endif

endmodule
